freq_det: RTL and testbench

Frequency detector for the ADPLL lock loop, sitting directly downstream of the reference-edge pulse generator in the `dco_clk` domain. It counts `dco_clk` cycles between successive one-cycle `ref_clk_pulse` events and compares each measured period against the frequency control word `fcw`. It outputs a signed frequency error per reference period and a lock indication driven by a consecutive-in-tolerance counter.

---
 rtl/fd_pkg.sv | 19 +
 rtl/fd_lock_fsm.sv | 89 ++++++++
 rtl/freq_det.sv | 119 +++++++++++
 tb/tb_freq_det.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fd_pkg.sv
// Shared types and default widths for the ADPLL frequency detector.
package fd_pkg;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      TRACK    = 2'd1,
      LOCKED   = 2'd2
   } lock_state_e;

   typedef enum logic {
      WAIT_FIRST = 1'b0,
      MEASURE    = 1'b1
   } meas_state_e;

   localparam int unsigned FD_CNT_W    = 16;
   localparam int unsigned FD_LOCK_TOL = 2;
   localparam int unsigned FD_LOCK_CYC = 8;

endpackage

// File: rtl/fd_lock_fsm.sv
// Lock qualifier: counts consecutive in-tolerance measurements and raises
// lock once LOCK_CYC of them have been seen in a row.
module fd_lock_fsm
   import fd_pkg::*;
#(
   parameter int unsigned CNT_W    = FD_CNT_W,
   parameter int unsigned LOCK_TOL = FD_LOCK_TOL,
   parameter int unsigned LOCK_CYC = FD_LOCK_CYC
) (
   input  logic                    dco_clk,
   input  logic                    rst,
   input  logic                    err_valid,
   input  logic signed [CNT_W:0]   freq_err,
   input  logic                    overflow,
   output logic                    lock
);

   localparam int unsigned        GOOD_W   = $clog2(LOCK_CYC + 1);
   localparam logic [GOOD_W-1:0]  GOOD_TGT = GOOD_W'(LOCK_CYC);
   localparam logic [CNT_W:0]     TOL      = (CNT_W + 1)'(LOCK_TOL);

   // Magnitude of a difference of two unsigned CNT_W values always fits
   // in CNT_W+1 unsigned bits, so the negation cannot wrap here.
   function automatic logic [CNT_W:0] err_mag(input logic signed [CNT_W:0] v);
      logic signed [CNT_W:0] neg;
      neg = -v;
      return v[CNT_W] ? $unsigned(neg) : $unsigned(v);
   endfunction

   lock_state_e        st_q, st_d;
   logic [GOOD_W-1:0]  good_q, good_d;
   logic [GOOD_W-1:0]  good_inc;
   logic               in_tol;
   logic               lock_q;

   assign in_tol   = !overflow && (err_mag(freq_err) <= TOL);
   assign good_inc = good_q + GOOD_W'(1);

   always_comb begin
      st_d   = st_q;
      good_d = good_q;
      if (err_valid) begin
         case (st_q)
            UNLOCKED: begin
               if (in_tol) begin
                  good_d = GOOD_W'(1);
                  st_d   = (LOCK_CYC == 1) ? LOCKED : TRACK;
               end
            end
            TRACK: begin
               if (in_tol) begin
                  good_d = good_inc;
                  if (good_inc == GOOD_TGT) st_d = LOCKED;
               end else begin
                  good_d = '0;
                  st_d   = UNLOCKED;
               end
            end
            LOCKED: begin
               if (!in_tol) begin
                  good_d = '0;
                  st_d   = UNLOCKED;
               end
            end
            default: begin
               good_d = '0;
               st_d   = UNLOCKED;
            end
         endcase
      end
   end

   // Stage p2: lock registered from the next state so it moves together
   // with the state, one cycle after the measurement strobe.
   always_ff @(posedge dco_clk) begin
      if (rst) begin
         st_q   <= UNLOCKED;
         good_q <= '0;
         lock_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         good_q <= good_d;
         lock_q <= (st_d == LOCKED);
      end
   end

   assign lock = lock_q;

endmodule

// File: rtl/freq_det.sv
// ADPLL frequency detector: measures dco_clk cycles between reference
// pulses, reports the signed error against fcw and qualifies lock.
module freq_det
   import fd_pkg::*;
#(
   parameter int unsigned CNT_W    = FD_CNT_W,
   parameter int unsigned LOCK_TOL = FD_LOCK_TOL,
   parameter int unsigned LOCK_CYC = FD_LOCK_CYC
) (
   input  logic                    dco_clk,
   input  logic                    rst,
   input  logic                    ref_clk_pulse,
   input  logic [CNT_W-1:0]        fcw,
   output logic [CNT_W-1:0]        period_cnt,
   output logic signed [CNT_W:0]   freq_err,
   output logic                    err_valid,
   output logic                    overflow,
   output logic                    lock
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
   endfunction

   function automatic logic signed [CNT_W:0] diff_ext(input logic [CNT_W-1:0] a,
                                                      input logic [CNT_W-1:0] b);
      return $signed({1'b0, a}) - $signed({1'b0, b});
   endfunction

   meas_state_e              meas_q, meas_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     sat_q, sat_d;
   logic                     vld_p0;
   logic [CNT_W-1:0]         period_p0;
   logic signed [CNT_W:0]    err_p0;

   logic                     vld_p1;
   logic [CNT_W-1:0]         period_p1;
   logic signed [CNT_W:0]    err_p1;
   logic                     ovf_p1;

   // The counter holds cycles-since-pulse minus one, so the closing pulse
   // cycle itself is counted by the saturating +1.
   assign period_p0 = sat_inc(cnt_q);
   assign err_p0    = diff_ext(period_p0, fcw);

   always_comb begin
      meas_d = meas_q;
      cnt_d  = cnt_q;
      sat_d  = sat_q;
      vld_p0 = 1'b0;
      case (meas_q)
         WAIT_FIRST: begin
            cnt_d = '0;
            sat_d = 1'b0;
            if (ref_clk_pulse) meas_d = MEASURE;
         end
         MEASURE: begin
            if (ref_clk_pulse) begin
               vld_p0 = 1'b1;
               cnt_d  = '0;
               sat_d  = 1'b0;
            end else begin
               cnt_d = sat_inc(cnt_q);
               sat_d = sat_q | (sat_inc(cnt_q) == CNT_MAX);
            end
         end
         default: begin
            meas_d = WAIT_FIRST;
            cnt_d  = '0;
            sat_d  = 1'b0;
         end
      endcase
   end

   // Stage p1: measurement results latched on the closing pulse and held.
   always_ff @(posedge dco_clk) begin
      if (rst) begin
         meas_q    <= WAIT_FIRST;
         cnt_q     <= '0;
         sat_q     <= 1'b0;
         vld_p1    <= 1'b0;
         period_p1 <= '0;
         err_p1    <= '0;
         ovf_p1    <= 1'b0;
      end else begin
         meas_q <= meas_d;
         cnt_q  <= cnt_d;
         sat_q  <= sat_d;
         vld_p1 <= vld_p0;
         if (vld_p0) begin
            period_p1 <= period_p0;
            err_p1    <= err_p0;
            ovf_p1    <= sat_q;
         end
      end
   end

   assign period_cnt = period_p1;
   assign freq_err   = err_p1;
   assign err_valid  = vld_p1;
   assign overflow   = ovf_p1;

   fd_lock_fsm #(
      .CNT_W    (CNT_W),
      .LOCK_TOL (LOCK_TOL),
      .LOCK_CYC (LOCK_CYC)
   ) u_lock (
      .dco_clk   (dco_clk),
      .rst       (rst),
      .err_valid (vld_p1),
      .freq_err  (err_p1),
      .overflow  (ovf_p1),
      .lock      (lock)
   );

endmodule

// File: tb/tb_freq_det.sv
// Bench for freq_det: vector table, hand-written corner sequences and
// randomized pulse trains against a cycle-level reference model.
module tb_freq_det;

   localparam int CNT_W    = 8;
   localparam int LOCK_TOL = 2;
   localparam int LOCK_CYC = 8;
   localparam int MAXC     = (1 << CNT_W) - 1;

   logic                  dco_clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  ref_clk_pulse = 1'b0;
   logic [CNT_W-1:0]      fcw = '0;
   logic [CNT_W-1:0]      period_cnt;
   logic signed [CNT_W:0] freq_err;
   logic                  err_valid;
   logic                  overflow;
   logic                  lock;

   int checks = 0;
   int errors = 0;

   freq_det #(
      .CNT_W    (CNT_W),
      .LOCK_TOL (LOCK_TOL),
      .LOCK_CYC (LOCK_CYC)
   ) dut (
      .dco_clk       (dco_clk),
      .rst           (rst),
      .ref_clk_pulse (ref_clk_pulse),
      .fcw           (fcw),
      .period_cnt    (period_cnt),
      .freq_err      (freq_err),
      .err_valid     (err_valid),
      .overflow      (overflow),
      .lock          (lock)
   );

   always #5 dco_clk = ~dco_clk;

   // Reference model state: time since last pulse and a run length of
   // consecutive good measurements; lock means run >= LOCK_CYC.
   bit m_armed  = 1'b0;
   int m_since  = 0;
   int m_streak = 0;
   bit m_vld    = 1'b0;
   bit m_ovf    = 1'b0;
   bit m_lock   = 1'b0;
   int m_period = 0;
   int m_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit p, input bit r, input logic [CNT_W-1:0] f);
      logic [31:0] act_v;
      logic [31:0] exp_v;
      logic [31:0] per_v;
      logic [31:0] err_v;
      ref_clk_pulse = p;
      rst           = r;
      fcw           = f;
      if (r) begin
         m_armed = 0; m_since = 0; m_streak = 0; m_vld = 0;
         m_ovf = 0; m_lock = 0; m_period = 0; m_err = 0;
      end else begin
         if (m_vld) begin
            if (!m_ovf && m_err <= LOCK_TOL && m_err >= -LOCK_TOL) m_streak++;
            else m_streak = 0;
            m_lock = (m_streak >= LOCK_CYC);
         end
         m_since++;
         m_vld = 0;
         if (p) begin
            if (m_armed) begin
               m_period = (m_since > MAXC) ? MAXC : m_since;
               m_ovf    = (m_since > MAXC);
               m_err    = m_period - int'(f);
               m_vld    = 1;
            end
            m_armed = 1;
            m_since = 0;
         end
      end
      @(posedge dco_clk);
      #1;
      per_v = m_period;
      err_v = m_err;
      act_v = {11'd0, err_valid, overflow, lock, period_cnt, freq_err};
      exp_v = {11'd0, m_vld, m_ovf, m_lock, per_v[CNT_W-1:0], err_v[CNT_W:0]};
      check("model", act_v, exp_v);
   endtask

   task automatic idle(input int n, input logic [CNT_W-1:0] f);
      for (int k = 0; k < n; k++) step(0, 0, f);
   endtask

   typedef struct {
      int gap;
      int fcw;
      int period;
      int err;
      bit ovf;
      bit lock;
   } vec_t;

   localparam int NT = 25;
   vec_t tbl [NT];

   initial begin
      bit prev_lock;
      int sel;
      int gap;
      logic [CNT_W-1:0] f;

      for (int i = 0; i < 8; i++) tbl[i] = '{100, 100, 100, 0, 1'b0, (i == 7)};
      tbl[8]  = '{100, 100, 100,   0, 1'b0, 1'b1};
      tbl[9]  = '{110, 100, 110,  10, 1'b0, 1'b0};
      for (int i = 10; i < 17; i++) tbl[i] = '{98, 100, 98, -2, 1'b0, 1'b0};
      tbl[17] = '{102, 100, 102,   2, 1'b0, 1'b1};
      tbl[18] = '{103, 100, 103,   3, 1'b0, 1'b0};
      tbl[19] = '{300, 100, 255, 155, 1'b1, 1'b0};
      tbl[20] = '{100, 100, 100,   0, 1'b0, 1'b0};
      tbl[21] = '{256, 255, 255,   0, 1'b1, 1'b0};
      tbl[22] = '{255, 255, 255,   0, 1'b0, 1'b0};
      tbl[23] = '{  2, 100,   2, -98, 1'b0, 1'b0};
      tbl[24] = '{ 50, 200,  50,-150, 1'b0, 1'b0};

      repeat (3) step(0, 1, CNT_W'(100));
      check("rst_period", 32'(period_cnt), 32'd0);
      check("rst_err", 32'($signed(freq_err)), 32'd0);
      check("rst_vld", 32'(err_valid), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_lock", 32'(lock), 32'd0);

      step(1, 0, CNT_W'(100));
      check("arm_no_vld", 32'(err_valid), 32'd0);
      step(0, 0, CNT_W'($urandom));
      prev_lock = 1'b0;
      for (int i = 0; i < NT; i++) begin
         for (int k = 0; k < tbl[i].gap - 2; k++) step(0, 0, CNT_W'($urandom));
         step(1, 0, CNT_W'(tbl[i].fcw));
         check("tbl_vld", 32'(err_valid), 32'd1);
         check("tbl_period", 32'(period_cnt), 32'(tbl[i].period));
         check("tbl_err", 32'($signed(freq_err)), 32'(tbl[i].err));
         check("tbl_ovf", 32'(overflow), 32'(tbl[i].ovf));
         check("tbl_lock_hold", 32'(lock), 32'(prev_lock));
         step(0, 0, CNT_W'($urandom));
         check("tbl_vld_drop", 32'(err_valid), 32'd0);
         check("tbl_lock", 32'(lock), 32'(tbl[i].lock));
         prev_lock = tbl[i].lock;
      end

      // back-to-back pulses
      step(1, 0, CNT_W'(10));
      check("b2b_p2", 32'(period_cnt), 32'd2);
      check("b2b_e2", 32'($signed(freq_err)), -32'sd8);
      step(1, 0, CNT_W'(10));
      check("b2b_vld", 32'(err_valid), 32'd1);
      check("b2b_p1", 32'(period_cnt), 32'd1);
      check("b2b_e1", 32'($signed(freq_err)), -32'sd9);
      step(1, 0, CNT_W'(1));
      check("b2b_vld2", 32'(err_valid), 32'd1);
      check("b2b_e0", 32'($signed(freq_err)), 32'd0);

      // fcw changes only take effect at the sampling pulse
      step(1, 0, CNT_W'(100));
      idle(99, CNT_W'(100));
      step(1, 0, CNT_W'(100));
      check("fcw_old_err", 32'($signed(freq_err)), 32'd0);
      idle(50, CNT_W'(120));
      idle(49, CNT_W'(77));
      step(1, 0, CNT_W'(120));
      check("fcw_new_period", 32'(period_cnt), 32'd100);
      check("fcw_new_err", 32'($signed(freq_err)), -32'sd20);

      // reset coincident with a pulse discards it
      step(1, 1, CNT_W'(100));
      check("rstp_vld", 32'(err_valid), 32'd0);
      check("rstp_period", 32'(period_cnt), 32'd0);
      idle(20, CNT_W'(100));
      step(1, 0, CNT_W'(100));
      check("rstp_rearm", 32'(err_valid), 32'd0);
      idle(99, CNT_W'(100));
      step(1, 0, CNT_W'(100));
      check("rstp_meas_vld", 32'(err_valid), 32'd1);
      check("rstp_meas_per", 32'(period_cnt), 32'd100);

      // reset mid-period drops the partial count
      idle(50, CNT_W'(100));
      step(0, 1, CNT_W'(100));
      idle(30, CNT_W'(100));
      step(1, 0, CNT_W'(100));
      check("rstm_rearm", 32'(err_valid), 32'd0);
      idle(99, CNT_W'(100));
      step(1, 0, CNT_W'(100));
      check("rstm_per", 32'(period_cnt), 32'd100);

      // randomized pulse trains, checked every cycle by the model
      for (int n = 0; n < 150; n++) begin
         sel = $urandom_range(0, 19);
         f   = CNT_W'(100);
         if (sel == 0)      gap = 1;
         else if (sel == 1) gap = $urandom_range(250, 300);
         else if (sel == 2) begin
            gap = $urandom_range(2, 200);
            f   = CNT_W'($urandom_range(1, 255));
         end else           gap = $urandom_range(97, 103);
         if (sel == 3) step(0, 1, f);
         for (int k = 0; k < gap - 1; k++) step(0, 0, CNT_W'($urandom));
         step(1, (sel == 4), f);
      end
      idle(3, CNT_W'(100));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
